// File: rtl/char_print_queue_if.sv
// Print-request and cell-write handshake bundle between the CPU side,
// the print queue and the character memory.
interface char_print_queue_if #(
    parameter int COL_W = 7,
    parameter int ROW_W = 6
);
    logic             in_valid;
    logic [5:0]       in_code;
    logic             in_ready;
    logic             out_valid;
    logic [5:0]       out_code;
    logic [COL_W-1:0] out_col;
    logic [ROW_W-1:0] out_row;
    logic             out_ready;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_code, out_col, out_row
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_code, out_col, out_row
    );
endinterface

// File: rtl/char_print_queue.sv
// Buffers CPU character prints in a small FIFO and turns them into (code, col, row)
// cell writes for the character memory, tracking a text cursor with newline/clear handling.
module char_print_queue #(
    parameter int         DEPTH      = 8,
    parameter int         COLS       = 80,
    parameter int         ROWS       = 60,
    parameter logic [5:0] NL_CODE    = 6'h3F,
    parameter logic [5:0] CLR_CODE   = 6'h3E,
    parameter logic [5:0] BLANK_CODE = 6'h00,
    parameter int         COL_W      = $clog2(COLS),
    parameter int         ROW_W      = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               reset,
    char_print_queue_if.slave  bus,
    output logic [COL_W-1:0]   cursor_col,
    output logic [ROW_W-1:0]   cursor_row,
    output logic               busy,
    output logic               overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [5:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    logic [5:0]       r_out_code;
    logic [COL_W-1:0] r_out_col;
    logic [ROW_W-1:0] r_out_row;
    logic [COL_W-1:0] r_cur_col;
    logic [ROW_W-1:0] r_cur_row;
    logic             r_overflow;
    logic [COL_W-1:0] r_clr_col;
    logic [ROW_W-1:0] r_clr_row;
    logic             r_clr_done;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_slot_free;
    logic [5:0]       w_head;
    logic             w_clr_start;
    logic             w_clr_step;
    logic             w_out_valid_nxt;
    logic [5:0]       w_out_code_nxt;
    logic [COL_W-1:0] w_out_col_nxt;
    logic [ROW_W-1:0] w_out_row_nxt;
    logic [COL_W-1:0] w_cur_col_nxt;
    logic [ROW_W-1:0] w_cur_row_nxt;

    function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] row);
        return (row == ROW_W'(ROWS - 1)) ? {ROW_W{1'b0}} : row + ROW_W'(1);
    endfunction

    function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] col);
        return (col == COL_W'(COLS - 1)) ? {COL_W{1'b0}} : col + COL_W'(1);
    endfunction

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == {CNT_W{1'b0}});
    assign w_push      = bus.in_valid && !w_full;
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_out_code;
    assign bus.out_col   = r_out_col;
    assign bus.out_row   = r_out_row;
    assign cursor_col    = r_cur_col;
    assign cursor_row    = r_cur_row;
    assign overflow      = r_overflow;
    assign busy          = !w_empty || r_out_valid || (r_state == ST_CLEAR);

    // FIFO storage; contents need no reset since the count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_code;
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (bus.in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, pop decision and next values of the output/cursor registers
    always_comb begin
        w_next_state    = r_state;
        w_pop           = 1'b0;
        w_clr_start     = 1'b0;
        w_clr_step      = 1'b0;
        w_out_valid_nxt = r_out_valid && !bus.out_ready;
        w_out_code_nxt  = r_out_code;
        w_out_col_nxt   = r_out_col;
        w_out_row_nxt   = r_out_row;
        w_cur_col_nxt   = r_cur_col;
        w_cur_row_nxt   = r_cur_row;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && w_slot_free) begin
                    w_pop = 1'b1;
                    if (w_head == NL_CODE) begin
                        w_cur_col_nxt = {COL_W{1'b0}};
                        w_cur_row_nxt = row_inc(r_cur_row);
                    end else if (w_head == CLR_CODE) begin
                        w_next_state = ST_CLEAR;
                        w_clr_start  = 1'b1;
                    end else begin
                        w_out_valid_nxt = 1'b1;
                        w_out_code_nxt  = w_head;
                        w_out_col_nxt   = r_cur_col;
                        w_out_row_nxt   = r_cur_row;
                        w_cur_col_nxt   = col_inc(r_cur_col);
                        w_cur_row_nxt   = (r_cur_col == COL_W'(COLS - 1)) ? row_inc(r_cur_row) : r_cur_row;
                    end
                end else begin
                    w_pop = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (w_slot_free) begin
                    if (!r_clr_done) begin
                        w_clr_step      = 1'b1;
                        w_out_valid_nxt = 1'b1;
                        w_out_code_nxt  = BLANK_CODE;
                        w_out_col_nxt   = r_clr_col;
                        w_out_row_nxt   = r_clr_row;
                    end else begin
                        // last blank has just transferred
                        w_next_state  = ST_IDLE;
                        w_cur_col_nxt = {COL_W{1'b0}};
                        w_cur_row_nxt = {ROW_W{1'b0}};
                    end
                end else begin
                    w_clr_step = 1'b0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output write register and text cursor
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_code  <= 6'h00;
            r_out_col   <= {COL_W{1'b0}};
            r_out_row   <= {ROW_W{1'b0}};
            r_cur_col   <= {COL_W{1'b0}};
            r_cur_row   <= {ROW_W{1'b0}};
        end else begin
            r_out_valid <= w_out_valid_nxt;
            r_out_code  <= w_out_code_nxt;
            r_out_col   <= w_out_col_nxt;
            r_out_row   <= w_out_row_nxt;
            r_cur_col   <= w_cur_col_nxt;
            r_cur_row   <= w_cur_row_nxt;
        end
    end

    // Raster address walker for clear-screen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_col  <= {COL_W{1'b0}};
            r_clr_row  <= {ROW_W{1'b0}};
            r_clr_done <= 1'b0;
        end else if (w_clr_start) begin
            r_clr_col  <= {COL_W{1'b0}};
            r_clr_row  <= {ROW_W{1'b0}};
            r_clr_done <= 1'b0;
        end else if (w_clr_step) begin
            if ((r_clr_col == COL_W'(COLS - 1)) && (r_clr_row == ROW_W'(ROWS - 1))) begin
                r_clr_done <= 1'b1;
            end else begin
                r_clr_col <= col_inc(r_clr_col);
                r_clr_row <= (r_clr_col == COL_W'(COLS - 1)) ? r_clr_row + ROW_W'(1) : r_clr_row;
            end
        end else begin
            r_clr_done <= r_clr_done;
        end
    end
endmodule

// File: tb/tb_char_print_queue.sv
// Directed bench for char_print_queue: a queue-based model of the expected cell
// writes is checked on every output transfer, plus hand-computed literal checks.
module tb_char_print_queue;
    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam logic [5:0] NL  = 6'h3F;
    localparam logic [5:0] CLR = 6'h3E;

    typedef struct packed {
        logic [5:0] code;
        logic [6:0] col;
        logic [5:0] row;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [6:0] cursor_col;
    logic [5:0] cursor_row;
    logic busy;
    logic overflow;

    char_print_queue_if bus ();

    char_print_queue dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  n_xfer = 0;
    int  mcol = 0;
    int  mrow = 0;
    wr_t exp_q[$];
    wr_t last_wr = '0;
    wr_t held = '0;
    bit  hold_prev = 1'b0;

    task automatic model_accept(input logic [5:0] c);
        if (c == NL) begin
            mcol = 0;
            mrow = (mrow + 1) % ROWS;
        end else if (c == CLR) begin
            for (int a = 0; a < COLS * ROWS; a++) begin
                exp_q.push_back({6'h00, 7'(a % COLS), 6'(a / COLS)});
            end
            mcol = 0;
            mrow = 0;
        end else begin
            exp_q.push_back({c, 7'(mcol), 6'(mrow)});
            mcol = mcol + 1;
            if (mcol == COLS) begin
                mcol = 0;
                mrow = (mrow + 1) % ROWS;
            end
        end
    endtask

    // Scoreboard: sampled on the falling edge, ahead of the edge that transfers
    always @(negedge clk) begin
        wr_t got;
        wr_t exp;
        got = {bus.out_code, bus.out_col, bus.out_row};
        if (!reset) begin
            exp_q.delete();
            mcol = 0;
            mrow = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (!bus.out_valid || got !== held) begin
                    errors++;
                    $display("FAIL hold got v=%0b %h/%0d/%0d expected v=1 %h/%0d/%0d",
                             bus.out_valid, got.code, got.col, got.row, held.code, held.col, held.row);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write got %h/%0d/%0d expected no write", got.code, got.col, got.row);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL write got %h/%0d/%0d expected %h/%0d/%0d",
                                 got.code, got.col, got.row, exp.code, exp.col, exp.row);
                    end
                end
                last_wr = got;
                n_xfer++;
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            held = got;
            if (bus.in_valid && bus.in_ready) begin
                model_accept(bus.in_code);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input logic [5:0] c);
        bus.in_valid = 1'b1;
        bus.in_code  = c;
        tick(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            tick(1);
            k++;
        end
        if (k >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got busy=%0b pending=%0d expected idle", busy, exp_q.size());
        end
        check("drain_busy", int'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.in_valid  = 1'b0;
        bus.in_code   = 6'h00;
        bus.out_ready = 1'b0;
        tick(2);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_cursor", int'({cursor_col, cursor_row}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        reset = 1'b1;
        tick(1);

        // 1: single print, latency and cursor
        bus.out_ready = 1'b1;
        push(6'h01);
        check("t1_lat_e", int'(bus.out_valid), 0);
        tick(1);
        check("t1_lat_e1", int'(bus.out_valid), 1);
        check("t1_code", int'(bus.out_code), 1);
        check("t1_col", int'(bus.out_col), 0);
        check("t1_row", int'(bus.out_row), 0);
        drain(50);
        check("t1_ccol", int'(cursor_col), 1);
        check("t1_crow", int'(cursor_row), 0);

        // 2: back-pressure holds the output stable
        do_reset();
        bus.out_ready = 1'b0;
        push(6'h01);
        push(6'h02);
        push(6'h03);
        tick(3);
        check("t2_valid", int'(bus.out_valid), 1);
        check("t2_code", int'(bus.out_code), 1);
        check("t2_col", int'(bus.out_col), 0);
        base = n_xfer;
        bus.out_ready = 1'b1;
        drain(50);
        check("t2_count", n_xfer - base, 3);
        check("t2_last_col", int'(last_wr.col), 2);
        check("t2_ccol", int'(cursor_col), 3);

        // 3: line wrap, newline and row wrap
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 80; i++) push(6'((i % 61) + 1));
        push(NL);
        drain(200);
        check("t3_last_col", int'(last_wr.col), 79);
        check("t3_last_row", int'(last_wr.row), 0);
        check("t3_ccol", int'(cursor_col), 0);
        check("t3_crow", int'(cursor_row), 2);
        for (int i = 0; i < 59; i++) push(NL);
        drain(200);
        check("t3_wrap_row", int'(cursor_row), 1);

        // 4: overflow with the output register already occupied
        do_reset();
        bus.out_ready = 1'b0;
        push(6'h05);
        base = n_xfer;
        for (int i = 0; i < 10; i++) begin
            push(6'(8'h10 + i));
            if (i == 6) check("t4_ready_7", int'(bus.in_ready), 1);
            if (i == 7) check("t4_full_8", int'(bus.in_ready), 0);
        end
        check("t4_overflow", int'(overflow), 1);
        bus.out_ready = 1'b1;
        drain(100);
        check("t4_count", n_xfer - base, 9);
        check("t4_last_code", int'(last_wr.code), 8'h17);
        check("t4_ovf_sticky", int'(overflow), 1);

        // 5: clear-screen from (5,3), then a push during a clear
        do_reset();
        bus.out_ready = 1'b1;
        push(NL); push(NL); push(NL);
        for (int i = 0; i < 5; i++) push(6'(8'h21 + i));
        drain(100);
        check("t5_pre_col", int'(cursor_col), 5);
        check("t5_pre_row", int'(cursor_row), 3);
        base = n_xfer;
        push(CLR);
        drain(6000);
        check("t5_count", n_xfer - base, 4800);
        check("t5_last", int'(last_wr), int'({6'h00, 7'd79, 6'd59}));
        check("t5_cursor", int'({cursor_col, cursor_row}), 0);
        push(CLR);
        tick(50);
        push(6'h22);
        drain(6000);
        check("t5_mid_last", int'(last_wr), int'({6'h22, 7'd0, 6'd0}));
        check("t5_mid_ccol", int'(cursor_col), 1);

        // 6: reset in the middle of a clear
        do_reset();
        bus.out_ready = 1'b1;
        push(CLR);
        tick(200);
        check("t6_busy_pre", int'(busy), 1);
        reset = 1'b0;
        #1;
        check("t6_out", int'({bus.out_valid, bus.out_code, bus.out_col, bus.out_row}), 0);
        check("t6_cursor", int'({cursor_col, cursor_row}), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_in_ready", int'(bus.in_ready), 1);
        tick(2);
        reset = 1'b1;
        tick(1);
        push(6'h07);
        drain(50);
        check("t6_after", int'(last_wr), int'({6'h07, 7'd0, 6'd0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
